tdc_stream_tx: RTL and testbench

Transmit side of the TDC-to-histogram stream. Captures per-shot TDC hits (timestamp plus intensity) into a ping-pong pair of shot buffers and replays them as a valid/ready beat stream: `TDC_Odata`, `TDC_Oint`, `TDC_Onum`, `TDC_Olast`. Sits between the TDC core and the histogram block, and absorbs histogram back-pressure for up to one shot in flight.

---
 rtl/tdc_stream_pkg.sv | 26 ++
 rtl/tdc_hit_bank.sv | 81 ++++++++
 rtl/tdc_stream_tx.sv | 236 +++++++++++++++++++++++
 tb/tb_tdc_stream_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_stream_pkg.sv
// Shared types and default sizes for the TDC transmit stream.
// Optional build macro used by tdc_stream_tx: TDC_TX_ZERO_BEAT_EN.
package tdc_stream_pkg;

  localparam int TDC_MAX_HITS = 3;
  localparam int TDC_DW       = 15;
  localparam int TDC_IW       = 4;
  localparam int TDC_OVF_W    = 8;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_CAP  = 2'd1,
    C_DROP = 2'd2
  } cap_state_e;

  typedef enum logic {
    O_IDLE = 1'b0,
    O_SEND = 1'b1
  } out_state_e;

  typedef struct packed {
    logic [TDC_DW-1:0] data;
    logic [TDC_IW-1:0] inten;
  } hit_entry_t;

endpackage

// File: rtl/tdc_hit_bank.sv
// One shot buffer: up to MAX_HITS {data, intensity} entries, a hit count and a full flag.
// Reads past the stored count return zero, which also yields the zero-hit beat payload.
module tdc_hit_bank
  import tdc_stream_pkg::*;
#(
  parameter int MAX_HITS = TDC_MAX_HITS,
  parameter int DW       = TDC_DW,
  parameter int IW       = TDC_IW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic [IW-1:0] wr_int,
  input  logic          commit,
  input  logic          rel,
  input  logic [1:0]    rd_idx,
  output logic          full,
  output logic [1:0]    cnt,
  output logic [DW-1:0] rd_data,
  output logic [IW-1:0] rd_int
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_HITS);

  logic [DW-1:0] data_r [MAX_HITS];
  logic [IW-1:0] int_r  [MAX_HITS];
  logic [1:0]    cnt_r;
  logic          full_r;
  logic          wr_ok_s;

  assign wr_ok_s = wr_en && (cnt_r < MAX_CNT);
  assign full    = full_r;
  assign cnt     = cnt_r;

  // Entry storage; extra hits beyond MAX_HITS are silently dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MAX_HITS; i++) begin
        data_r[i] <= '0;
        int_r[i]  <= '0;
      end
    end else if (wr_ok_s) begin
      data_r[cnt_r] <= wr_data;
      int_r[cnt_r]  <= wr_int;
    end
  end

  // Hit count and full flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r  <= 2'd0;
      full_r <= 1'b0;
    end else if (flush || rel) begin
      cnt_r  <= 2'd0;
      full_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        cnt_r <= cnt_r + 2'd1;
      end
      if (commit) begin
        full_r <= 1'b1;
      end
    end
  end

  // Read port.
  always_comb begin
    rd_data = '0;
    rd_int  = '0;
    if (rd_idx < cnt_r) begin
      rd_data = data_r[rd_idx];
      rd_int  = int_r[rd_idx];
    end else begin
      rd_data = '0;
      rd_int  = '0;
    end
  end

endmodule

// File: rtl/tdc_stream_tx.sv
// TDC shot capture into ping-pong banks, replayed as a valid/ready beat stream.
// Define TDC_TX_ZERO_BEAT_EN to emit one beat for shots that saw no hits.
module tdc_stream_tx
  import tdc_stream_pkg::*;
#(
  parameter int MAX_HITS = TDC_MAX_HITS,
  parameter int DW       = TDC_DW,
  parameter int IW       = TDC_IW,
  parameter int OVF_W    = TDC_OVF_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             TX_En,
  input  logic             shot_start,
  input  logic             shot_end,
  input  logic             hit_valid,
  input  logic [DW-1:0]    hit_data,
  input  logic [IW-1:0]    hit_int,
  output logic             TDC_Ovalid,
  input  logic             TDC_Oready,
  output logic [DW-1:0]    TDC_Odata,
  output logic [IW-1:0]    TDC_Oint,
  output logic [1:0]       TDC_Onum,
  output logic             TDC_Olast,
  output logic [OVF_W-1:0] ovf_cnt,
  input  logic             ovf_clr
);

`ifdef TDC_TX_ZERO_BEAT_EN
  localparam logic ZERO_BEAT = 1'b1;
`else
  localparam logic ZERO_BEAT = 1'b0;
`endif

  cap_state_e cap_state_r, cap_next_s;
  out_state_e out_state_r, out_next_s;
  logic       wbank_r, next_wbank_s, rbank_r, next_rbank_s;
  logic       wr_en_s, commit_s, ovf_inc_s;
  logic       load_s, load_bank_s, adv_s, rel_s;
  logic [1:0] beat_idx_r;

  logic [1:0]    full_s;
  logic [1:0]    cnt_s     [2];
  logic [1:0]    rd_idx_s  [2];
  logic [DW-1:0] rd_data_s [2];
  logic [IW-1:0] rd_int_s  [2];

  for (genvar g = 0; g < 2; g++) begin : g_bank
    // The bank being streamed reads the next beat; any other bank presents beat 0.
    assign rd_idx_s[g] = (rbank_r == 1'(g) && out_state_r == O_SEND) ? beat_idx_r + 2'd1 : 2'd0;

    tdc_hit_bank #(.MAX_HITS(MAX_HITS), .DW(DW), .IW(IW)) u_bank (
      .clk     (clk),
      .rstn    (rstn),
      .flush   (!TX_En),
      .wr_en   (wr_en_s && wbank_r == 1'(g)),
      .wr_data (hit_data),
      .wr_int  (hit_int),
      .commit  (commit_s && wbank_r == 1'(g)),
      .rel     (rel_s && rbank_r == 1'(g)),
      .rd_idx  (rd_idx_s[g]),
      .full    (full_s[g]),
      .cnt     (cnt_s[g]),
      .rd_data (rd_data_s[g]),
      .rd_int  (rd_int_s[g])
    );
  end

  // Capture FSM next state; a restart inside a shot commits first, then tests the new bank.
  always_comb begin
    cap_next_s   = cap_state_r;
    next_wbank_s = wbank_r;
    wr_en_s      = 1'b0;
    commit_s     = 1'b0;
    ovf_inc_s    = 1'b0;
    case (cap_state_r)
      C_IDLE: begin
        if (shot_start) begin
          if (full_s[wbank_r]) begin
            cap_next_s = C_DROP;
            ovf_inc_s  = 1'b1;
          end else begin
            cap_next_s = C_CAP;
          end
        end else begin
          cap_next_s = C_IDLE;
        end
      end
      C_CAP: begin
        wr_en_s = hit_valid;
        if (shot_start || shot_end) begin
          commit_s     = ZERO_BEAT || hit_valid || (cnt_s[wbank_r] != 2'd0);
          next_wbank_s = wbank_r ^ commit_s;
          if (shot_start) begin
            if (full_s[next_wbank_s]) begin
              cap_next_s = C_DROP;
              ovf_inc_s  = 1'b1;
            end else begin
              cap_next_s = C_CAP;
            end
          end else begin
            cap_next_s = C_IDLE;
          end
        end else begin
          cap_next_s = C_CAP;
        end
      end
      C_DROP: begin
        if (shot_end) begin
          cap_next_s = C_IDLE;
        end else begin
          cap_next_s = C_DROP;
        end
      end
      default: cap_next_s = C_IDLE;
    endcase
    if (!TX_En) begin
      cap_next_s   = C_IDLE;
      next_wbank_s = 1'b0;
      wr_en_s      = 1'b0;
      commit_s     = 1'b0;
      ovf_inc_s    = 1'b0;
    end else begin
      cap_next_s = cap_next_s;
    end
  end

  // Output FSM next state, including back-to-back hand-over to the other bank.
  always_comb begin
    out_next_s   = out_state_r;
    next_rbank_s = rbank_r;
    load_s       = 1'b0;
    load_bank_s  = rbank_r;
    adv_s        = 1'b0;
    rel_s        = 1'b0;
    case (out_state_r)
      O_IDLE: begin
        if (full_s[rbank_r]) begin
          load_s     = 1'b1;
          out_next_s = O_SEND;
        end else begin
          out_next_s = O_IDLE;
        end
      end
      O_SEND: begin
        if (TDC_Ovalid && TDC_Oready) begin
          if (TDC_Olast) begin
            rel_s        = 1'b1;
            next_rbank_s = ~rbank_r;
            if (full_s[~rbank_r]) begin
              load_s      = 1'b1;
              load_bank_s = ~rbank_r;
              out_next_s  = O_SEND;
            end else begin
              out_next_s = O_IDLE;
            end
          end else begin
            adv_s = 1'b1;
          end
        end else begin
          out_next_s = O_SEND;
        end
      end
      default: out_next_s = O_IDLE;
    endcase
    if (!TX_En) begin
      out_next_s   = O_IDLE;
      next_rbank_s = 1'b0;
      load_s       = 1'b0;
      adv_s        = 1'b0;
      rel_s        = 1'b0;
    end else begin
      out_next_s = out_next_s;
    end
  end

  // State and bank pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_state_r <= C_IDLE;
      out_state_r <= O_IDLE;
      wbank_r     <= 1'b0;
      rbank_r     <= 1'b0;
    end else begin
      cap_state_r <= cap_next_s;
      out_state_r <= out_next_s;
      wbank_r     <= next_wbank_s;
      rbank_r     <= next_rbank_s;
    end
  end

  // Beat output registers; held while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      TDC_Ovalid <= 1'b0;
      TDC_Odata  <= '0;
      TDC_Oint   <= '0;
      TDC_Onum   <= 2'd0;
      TDC_Olast  <= 1'b0;
      beat_idx_r <= 2'd0;
    end else if (!TX_En) begin
      TDC_Ovalid <= 1'b0;
      TDC_Odata  <= '0;
      TDC_Oint   <= '0;
      TDC_Onum   <= 2'd0;
      TDC_Olast  <= 1'b0;
      beat_idx_r <= 2'd0;
    end else if (load_s) begin
      TDC_Ovalid <= 1'b1;
      TDC_Odata  <= rd_data_s[load_bank_s];
      TDC_Oint   <= rd_int_s[load_bank_s];
      TDC_Onum   <= cnt_s[load_bank_s];
      TDC_Olast  <= (cnt_s[load_bank_s] <= 2'd1);
      beat_idx_r <= 2'd0;
    end else if (adv_s) begin
      TDC_Odata  <= rd_data_s[rbank_r];
      TDC_Oint   <= rd_int_s[rbank_r];
      TDC_Olast  <= (beat_idx_r + 2'd2 == TDC_Onum);
      beat_idx_r <= beat_idx_r + 2'd1;
    end else if (rel_s) begin
      TDC_Ovalid <= 1'b0;
    end
  end

  // Dropped-shot counter; a clear beats a coincident increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end else if (ovf_inc_s && (ovf_cnt != {OVF_W{1'b1}})) begin
      ovf_cnt <= ovf_cnt + {{(OVF_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_tdc_stream_tx.sv
// Scoreboard bench for tdc_stream_tx: expected beats are queued as shots are driven
// and popped whenever the DUT completes a valid/ready handshake.
module tb_tdc_stream_tx;

  typedef struct packed {
    logic [14:0] d;
    logic [3:0]  i;
    logic [1:0]  n;
    logic        l;
  } beat_t;

  logic        clk, rstn, TX_En, shot_start, shot_end, hit_valid;
  logic [14:0] hit_data;
  logic [3:0]  hit_int;
  logic        TDC_Ovalid, TDC_Oready, TDC_Olast, ovf_clr;
  logic [14:0] TDC_Odata;
  logic [3:0]  TDC_Oint;
  logic [1:0]  TDC_Onum;
  logic [7:0]  ovf_cnt;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_mis = 0;

  tdc_stream_tx dut (
    .clk(clk), .rstn(rstn), .TX_En(TX_En), .shot_start(shot_start), .shot_end(shot_end),
    .hit_valid(hit_valid), .hit_data(hit_data), .hit_int(hit_int),
    .TDC_Ovalid(TDC_Ovalid), .TDC_Oready(TDC_Oready), .TDC_Odata(TDC_Odata),
    .TDC_Oint(TDC_Oint), .TDC_Onum(TDC_Onum), .TDC_Olast(TDC_Olast),
    .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic beat_t mk(input logic [14:0] d, input logic [3:0] i,
                               input logic [1:0] n, input logic l);
    beat_t b;
    b.d = d; b.i = i; b.n = n; b.l = l;
    return b;
  endfunction

  // One clock; a handshake seen before the edge is scored against the queue head.
  task automatic tick();
    beat_t got, exp;
    @(negedge clk);
    if (TDC_Ovalid && TDC_Oready) begin
      got = {TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast};
      n_cmp++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL beat_unexpected: got d=%h i=%h n=%0d l=%0b, required no beat",
                 got.d, got.i, got.n, got.l);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_mis++;
          $display("FAIL beat: got d=%h i=%h n=%0d l=%0b, required d=%h i=%h n=%0d l=%0b",
                   got.d, got.i, got.n, got.l, exp.d, exp.i, exp.n, exp.l);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    shot_start = 1'b1; tick(); shot_start = 1'b0;
  endtask

  task automatic pulse_end();
    shot_end = 1'b1; tick(); shot_end = 1'b0;
  endtask

  task automatic hit(input logic [14:0] d, input logic [3:0] i);
    hit_valid = 1'b1; hit_data = d; hit_int = i;
    tick();
    hit_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((sb.size() != 0 || TDC_Ovalid) && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (sb.size() != 0 || TDC_Ovalid) begin
      n_mis++;
      $display("FAIL drain_timeout: got %0d beats pending valid=%0b, required 0 pending", sb.size(), TDC_Ovalid);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; TX_En = 1'b1; shot_start = 1'b0; shot_end = 1'b0; hit_valid = 1'b0;
    hit_data = '0; hit_int = '0; TDC_Oready = 1'b1; ovf_clr = 1'b0;
    #2;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    n_cmp++; if (TDC_Ovalid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %0b required 0", TDC_Ovalid); end
    n_cmp++; if (TDC_Odata !== 15'h0) begin n_mis++; $display("FAIL reset_data: got %h required 0", TDC_Odata); end
    n_cmp++; if (TDC_Oint !== 4'h0) begin n_mis++; $display("FAIL reset_int: got %h required 0", TDC_Oint); end
    n_cmp++; if (TDC_Onum !== 2'd0) begin n_mis++; $display("FAIL reset_num: got %0d required 0", TDC_Onum); end
    n_cmp++; if (TDC_Olast !== 1'b0) begin n_mis++; $display("FAIL reset_last: got %0b required 0", TDC_Olast); end
    n_cmp++; if (ovf_cnt !== 8'd0) begin n_mis++; $display("FAIL reset_ovf: got %0d required 0", ovf_cnt); end
  endtask

  task automatic test_basic_shot();
    TDC_Oready = 1'b1;
    pulse_start();
    hit(15'h1234, 4'd5);
    hit(15'h1235, 4'd6);
    hit(15'h0100, 4'd2);
    sb.push_back(mk(15'h1234, 4'd5, 2'd3, 1'b0));
    sb.push_back(mk(15'h1235, 4'd6, 2'd3, 1'b0));
    sb.push_back(mk(15'h0100, 4'd2, 2'd3, 1'b1));
    pulse_end();
    n_cmp++; if (TDC_Ovalid !== 1'b0) begin n_mis++; $display("FAIL latency_n1: got valid=%0b required 0", TDC_Ovalid); end
    tick();
    n_cmp++; if (TDC_Ovalid !== 1'b1) begin n_mis++; $display("FAIL latency_n2: got valid=%0b required 1", TDC_Ovalid); end
    repeat (3) tick();
    n_cmp++; if (sb.size() != 0) begin n_mis++; $display("FAIL throughput: got %0d beats left required 0", sb.size()); end
    n_cmp++; if (TDC_Ovalid !== 1'b0) begin n_mis++; $display("FAIL valid_after_last: got %0b required 0", TDC_Ovalid); end
  endtask

  task automatic test_hit_limit();
    pulse_start();
    hit(15'h0001, 4'd1); hit(15'h0002, 4'd2); hit(15'h0003, 4'd3);
    hit(15'h0004, 4'd4); hit(15'h0005, 4'd5);
    sb.push_back(mk(15'h0001, 4'd1, 2'd3, 1'b0));
    sb.push_back(mk(15'h0002, 4'd2, 2'd3, 1'b0));
    sb.push_back(mk(15'h0003, 4'd3, 2'd3, 1'b1));
    pulse_end();
    drain(20);
    n_cmp++; if (ovf_cnt !== 8'd0) begin n_mis++; $display("FAIL hit_limit_ovf: got %0d required 0", ovf_cnt); end
  endtask

  task automatic test_backpressure();
    TDC_Oready = 1'b0;
    pulse_start(); hit(15'h0AAA, 4'd1); pulse_end();
    sb.push_back(mk(15'h0AAA, 4'd1, 2'd1, 1'b1));
    pulse_start(); hit(15'h0BBB, 4'd2); pulse_end();
    sb.push_back(mk(15'h0BBB, 4'd2, 2'd1, 1'b1));
    pulse_start(); hit(15'h0CCC, 4'd3); pulse_end();
    n_cmp++; if (ovf_cnt !== 8'd1) begin n_mis++; $display("FAIL ovf_drop: got %0d required 1", ovf_cnt); end
    n_cmp++;
    if (TDC_Ovalid !== 1'b1 || TDC_Odata !== 15'h0AAA || TDC_Olast !== 1'b1) begin
      n_mis++;
      $display("FAIL stall_hold: got v=%0b d=%h l=%0b required v=1 d=0aaa l=1", TDC_Ovalid, TDC_Odata, TDC_Olast);
    end
    shot_start = 1'b1; ovf_clr = 1'b1;
    tick();
    shot_start = 1'b0; ovf_clr = 1'b0;
    n_cmp++; if (ovf_cnt !== 8'd0) begin n_mis++; $display("FAIL ovf_clr_wins: got %0d required 0", ovf_cnt); end
    pulse_end();
    TDC_Oready = 1'b1;
    drain(20);
  endtask

  task automatic test_zero_hit();
    TDC_Oready = 1'b1;
    pulse_start();
    pulse_end();
`ifdef TDC_TX_ZERO_BEAT_EN
    sb.push_back(mk(15'h0, 4'h0, 2'd0, 1'b1));
    tick();
    n_cmp++; if (TDC_Ovalid !== 1'b1) begin n_mis++; $display("FAIL zero_beat_valid: got %0b required 1", TDC_Ovalid); end
`else
    tick();
    n_cmp++; if (TDC_Ovalid !== 1'b0) begin n_mis++; $display("FAIL zero_discard_valid: got %0b required 0", TDC_Ovalid); end
`endif
    drain(10);
    repeat (3) tick();
    n_cmp++; if (ovf_cnt !== 8'd0) begin n_mis++; $display("FAIL zero_ovf: got %0d required 0", ovf_cnt); end
  endtask

  task automatic test_coincident();
    TDC_Oready = 1'b1;
    pulse_start();
    hit(15'h0011, 4'd1);
    hit_valid = 1'b1; hit_data = 15'h0022; hit_int = 4'd2; shot_end = 1'b1;
    tick();
    hit_valid = 1'b0; shot_end = 1'b0;
    sb.push_back(mk(15'h0011, 4'd1, 2'd2, 1'b0));
    sb.push_back(mk(15'h0022, 4'd2, 2'd2, 1'b1));
    drain(20);
    pulse_start();
    hit(15'h0033, 4'd3);
    sb.push_back(mk(15'h0033, 4'd3, 2'd1, 1'b1));
    pulse_start();
    hit(15'h0044, 4'd4);
    sb.push_back(mk(15'h0044, 4'd4, 2'd1, 1'b1));
    pulse_end();
    drain(20);
    n_cmp++; if (ovf_cnt !== 8'd0) begin n_mis++; $display("FAIL restart_ovf: got %0d required 0", ovf_cnt); end
  endtask

  task automatic test_flush_and_reset();
    TDC_Oready = 1'b0;
    pulse_start(); hit(15'h0321, 4'd7); pulse_end();
    pulse_start(); hit(15'h0322, 4'd8); pulse_end();
    pulse_start(); pulse_end();
    n_cmp++; if (TDC_Ovalid !== 1'b1) begin n_mis++; $display("FAIL flush_pre_valid: got %0b required 1", TDC_Ovalid); end
    TX_En = 1'b0;
    tick();
    n_cmp++; if (TDC_Ovalid !== 1'b0) begin n_mis++; $display("FAIL flush_valid: got %0b required 0", TDC_Ovalid); end
    n_cmp++; if (ovf_cnt !== 8'd1) begin n_mis++; $display("FAIL flush_ovf_kept: got %0d required 1", ovf_cnt); end
    TX_En = 1'b1; TDC_Oready = 1'b1;
    repeat (4) tick();
    n_cmp++; if (TDC_Ovalid !== 1'b0) begin n_mis++; $display("FAIL flush_banks_empty: got valid=%0b required 0", TDC_Ovalid); end
    pulse_start(); hit(15'h0555, 4'd9);
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({TDC_Ovalid, TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast, ovf_cnt} !== 31'd0) begin
      n_mis++;
      $display("FAIL rst_mid_shot: got v=%0b d=%h i=%h n=%0d l=%0b ovf=%0d required all 0",
               TDC_Ovalid, TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast, ovf_cnt);
    end
    tick();
    rstn = 1'b1;
    pulse_end();
    repeat (3) tick();
    n_cmp++; if (TDC_Ovalid !== 1'b0) begin n_mis++; $display("FAIL rst_partial_lost: got valid=%0b required 0", TDC_Ovalid); end
  endtask

  initial begin
    test_reset();
    test_basic_shot();
    test_hit_limit();
    test_backpressure();
    test_zero_hit();
    test_coincident();
    test_flush_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
